fetch_sequencer: RTL

- Program-sequencing front end of the processor core.
- Owns the program counter and drives the instruction memory address. It presents the fetched 9-bit instruction to decode.
- Implements the start/done run handshake that the top level exposes to the test bench.
- Counts executed cycles for performance reporting.

---
 rtl/fetch_sequencer_pkg.sv | 20 ++
 rtl/fetch_sequencer_pc_next_logic.sv | 40 ++++
 rtl/fetch_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and types for the program-sequencing front end.
// Decode and the top level import the same widths and halt encoding from here.
package fetch_sequencer_pkg;

    localparam int PC_WIDTH    = 10;
    localparam int INSTR_WIDTH = 9;
    localparam int OFF_WIDTH   = 8;
    localparam int CNT_WIDTH   = 16;

    localparam logic [PC_WIDTH-1:0]    START_ADDR = '0;
    localparam logic [INSTR_WIDTH-1:0] HALT_INSTR = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_pc_next_logic.sv
// Next program counter selection for the fetch sequencer.
// Ports:
//   pc            current program counter
//   stall, halt   either one holds the PC and masks jump/branch
//   jump_en       absolute jump to jump_target (wins over branch)
//   branch_en     relative branch by signed branch_offset
//   pc_next       PC for the next cycle
//   wrap          sequential increment rolled over from all-ones
module pc_next_logic
    import fetch_sequencer_pkg::*;
(
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 stall,
    input  logic                 halt,
    input  logic                 jump_en,
    input  logic [PC_WIDTH-1:0]  jump_target,
    input  logic                 branch_en,
    input  logic [OFF_WIDTH-1:0] branch_offset,
    output logic [PC_WIDTH-1:0]  pc_next,
    output logic                 wrap
);

    always_comb begin
        pc_next = pc;
        wrap    = 1'b0;
        if (!stall && !halt) begin
            if (jump_en) begin
                pc_next = jump_target;
            end else if (branch_en) begin
                // Sign-extend the offset; the sum is taken modulo 2^PC_WIDTH.
                pc_next = pc + PC_WIDTH'($signed(branch_offset));
            end else begin
                pc_next = pc + PC_WIDTH'(1);
                // Only the sequential path reports a wrap.
                wrap    = &pc;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-sequencing front end: owns the PC, drives the instruction memory
// address, passes the fetched instruction to decode, runs the start/done
// handshake and counts RUN cycles.
// Ports:
//   clk, reset      rising-edge clock, async active-high reset
//   start           level; while high the core reloads, program runs after it falls
//   stall           hold PC/instruction this cycle
//   jump_en/target  absolute jump request
//   branch_en/off   relative branch request
//   imem_data       combinational ROM data at imem_addr
//   imem_addr       current PC
//   instr           imem_data passthrough
//   instr_valid     instr executes this cycle
//   done            program halted (registered)
//   cycle_cnt       saturating RUN cycle count since last start
//   pc_wrap         sticky sequential PC wrap
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// ARMED  | start seen, PC/counters reloaded, waiting for start to fall
// RUN    | issuing instructions
// HALTED | halt instruction executed, outputs frozen, done high
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   jump_en,
    input  logic [PC_WIDTH-1:0]    jump_target,
    input  logic                   branch_en,
    input  logic [OFF_WIDTH-1:0]   branch_offset,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   cycle_cnt,
    output logic                   pc_wrap
);

    fetch_state_t          state_q;
    fetch_state_t          state_next;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [PC_WIDTH-1:0]   pc_next;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  wrap_q;
    logic                  done_q;
    logic                  wrap;
    logic                  halt;
    logic                  run;

    assign run  = (state_q == RUN);
    assign halt = (imem_data == HALT_INSTR);

    pc_next_logic u_pc_next (
        .pc            (pc_q),
        .stall         (stall),
        .halt          (halt),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .branch_en     (branch_en),
        .branch_offset (branch_offset),
        .pc_next       (pc_next),
        .wrap          (wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        if (start) begin
            state_next = ARMED;
        end else begin
            case (state_q)
                IDLE:    state_next = IDLE;
                ARMED:   state_next = RUN;
                RUN:     if (!stall && halt) state_next = HALTED;
                HALTED:  state_next = HALTED;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= START_ADDR;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // done follows the state being entered so it is high exactly in HALTED.
            done_q <= (state_next == HALTED);
            if (start) begin
                pc_q   <= START_ADDR;
                cnt_q  <= '0;
                wrap_q <= 1'b0;
            end else if (run) begin
                pc_q <= pc_next;
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
                if (wrap) wrap_q <= 1'b1;
            end
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = imem_data;
    assign instr_valid = run && !stall;
    assign done        = done_q;
    assign cycle_cnt   = cnt_q;
    assign pc_wrap     = wrap_q;

endmodule
